lcd_bus_driver: RTL and testbench
=================================

LCD_BUS_DRIVER -- requirements
Module: lcd_bus_driver

Interface
REQ-001 Parameter T_POWERUP, default 2000000, power-on wait in clk cycles (40 ms at 50 MHz).
REQ-002 Parameter T_SETUP, default 2, RS/RW/data setup cycles before E rises.
REQ-003 Parameter T_EPW, default 25, E high width in cycles.
REQ-004 Parameter T_HOLD, default 2, cycles after E falls before the next phase.
REQ-005 Parameter T_EXEC, default 2000, execution wait for normal commands (40 us).
REQ-006 Parameter T_EXEC_LONG, default 82000, execution wait for clear/home (1.64 ms).
REQ-007 clk  input  1  system clock; all state changes on its rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 cmd_valid  input  1  upstream offers a command word.
REQ-010 cmd_data  input  10  {RS, RW, DB7..DB0}, bit 9 = RS, bit 8 = RW.
REQ-011 cmd_ready  output  1  block can accept a command this cycle.
REQ-012 busy  output  1  high whenever not in IDLE.
REQ-013 lcd_rs, lcd_rw, lcd_e  output  1 each  LCD control pins.
REQ-014 lcd_data  output  8  LCD DB7..DB0.
REQ-015 lcd_data_oe  output  1  bus drive enable (1 = block drives lcd_data).

Function
REQ-016 The FSM states SHALL be POWERUP, IDLE, SETUP, PULSE, HOLD and WAIT; a single down-counter of at least 22 bits SHALL time all states.
REQ-017 POWERUP SHALL last T_POWERUP cycles, then move to IDLE; cmd_ready = 0 throughout.
REQ-018 cmd_ready SHALL equal (state == IDLE); busy SHALL equal its inverse.
REQ-019 A command SHALL be accepted only on a rising edge with cmd_valid = 1 and cmd_ready = 1; cmd_data is latched on that edge and never sampled otherwise.
REQ-020 On accept: lcd_rs, lcd_rw and lcd_data take the latched values, lcd_data_oe = ~RW, and the FSM enters SETUP.
REQ-021 SETUP SHALL last T_SETUP cycles with lcd_e = 0; PULSE SHALL last T_EPW cycles with lcd_e = 1; HOLD SHALL last T_HOLD cycles with lcd_e = 0.
REQ-022 lcd_rs, lcd_rw, lcd_data and lcd_data_oe SHALL stay stable from accept through the end of HOLD.
REQ-023 WAIT SHALL last T_EXEC_LONG cycles if RS = 0, RW = 0, DB[7:2] = 0 and DB[1:0] != 0 (clear/home); otherwise T_EXEC cycles. The FSM then enters IDLE.
REQ-024 Accept-to-ready latency SHALL be exactly T_SETUP + T_EPW + T_HOLD + wait cycles.
REQ-025 If cmd_valid is high in the first IDLE cycle, the command SHALL be accepted in that cycle, giving back-to-back operation with no idle gap.
REQ-026 cmd_valid while cmd_ready = 0 SHALL have no effect.
REQ-027 In IDLE, lcd_rs, lcd_rw, lcd_data and lcd_data_oe SHALL hold their last values, and lcd_e = 0.
REQ-028 lcd_e SHALL be registered and glitch-free; it is high only in PULSE.
REQ-029 All timing parameters SHALL be at least 1; a value of 0 is treated as 1.

Reset
REQ-030 While rst_n = 0, outputs SHALL be forced asynchronously to: lcd_e = 0, lcd_rs = 0, lcd_rw = 0, lcd_data = 0, lcd_data_oe = 0, cmd_ready = 0, busy = 1; the FSM is held in POWERUP with the counter loaded to T_POWERUP.
REQ-031 Reset asserted mid-transaction SHALL abort the transaction; lcd_e falls immediately and the full power-up wait restarts after release.

Verification (T_POWERUP=10, T_SETUP=2, T_EPW=4, T_HOLD=2, T_EXEC=8, T_EXEC_LONG=20)
REQ-032 Release rst_n -> cmd_ready rises exactly 10 cycles later; lcd_e = 0 throughout.
REQ-033 Send 0x030 (function set) -> lcd_rs = 0, lcd_rw = 0, lcd_data = 0x30, lcd_data_oe = 1; lcd_e high for exactly 4 cycles starting 2 cycles after accept; cmd_ready returns 16 cycles after accept.
REQ-034 Send 0x001 (clear) -> cmd_ready returns 28 cycles after accept; send 0x200 (RS = 1 data write of 0x00) -> 16 cycles.
REQ-035 Hold cmd_valid high with 0x030 then 0x20C -> the second command is accepted in the first IDLE cycle; cmd_data changes while busy are ignored; data is stable across each E pulse.
REQ-036 Assert rst_n during PULSE -> lcd_e = 0 in the same cycle with no clock edge; after release the 10-cycle power-up repeats before cmd_ready = 1.
REQ-037 Send 0x1FF (RW = 1) -> lcd_data_oe = 0 during the transaction and lcd_rw = 1; the WAIT phase is 8 cycles.

Source files
------------

// File: rtl/lcd_bus_driver.sv
// HD44780-style LCD bus sequencer: power-up wait, then one command per
// accept with setup / E-pulse / hold / execution-wait phases.
module lcd_bus_driver #(
    parameter int unsigned T_POWERUP   = 2000000,
    parameter int unsigned T_SETUP     = 2,
    parameter int unsigned T_EPW       = 25,
    parameter int unsigned T_HOLD      = 2,
    parameter int unsigned T_EXEC      = 2000,
    parameter int unsigned T_EXEC_LONG = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [9:0] cmd_data,
    output logic       cmd_ready,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       lcd_data_oe
);

    // Zero-valued timings are clamped to one cycle.
    localparam logic [31:0] P_PU  = (T_POWERUP   == 0) ? 32'd1 : T_POWERUP;
    localparam logic [31:0] P_SU  = (T_SETUP     == 0) ? 32'd1 : T_SETUP;
    localparam logic [31:0] P_EPW = (T_EPW       == 0) ? 32'd1 : T_EPW;
    localparam logic [31:0] P_HD  = (T_HOLD      == 0) ? 32'd1 : T_HOLD;
    localparam logic [31:0] P_EX  = (T_EXEC      == 0) ? 32'd1 : T_EXEC;
    localparam logic [31:0] P_EXL = (T_EXEC_LONG == 0) ? 32'd1 : T_EXEC_LONG;

    typedef enum logic [2:0] {
        S_POWERUP,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        rs_q, rs_d;
    logic        rw_q, rw_d;
    logic [7:0]  data_q, data_d;
    logic        oe_q, oe_d;
    logic        e_q, e_d;
    logic        last;
    logic        is_long;

    assign last    = (cnt_q <= 32'd1);
    // Clear display / return home need the long execution wait.
    assign is_long = !rs_q && !rw_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        rw_d    = rw_q;
        data_d  = data_q;
        oe_d    = oe_q;
        case (state_q)
            S_POWERUP: begin
                if (last) state_d = S_IDLE;
                else      cnt_d   = cnt_q - 32'd1;
            end
            S_IDLE: begin
                if (cmd_valid) begin
                    rs_d    = cmd_data[9];
                    rw_d    = cmd_data[8];
                    data_d  = cmd_data[7:0];
                    oe_d    = ~cmd_data[8];
                    state_d = S_SETUP;
                    cnt_d   = P_SU;
                end
            end
            S_SETUP: begin
                if (last) begin
                    state_d = S_PULSE;
                    cnt_d   = P_EPW;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_PULSE: begin
                if (last) begin
                    state_d = S_HOLD;
                    cnt_d   = P_HD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_HOLD: begin
                if (last) begin
                    state_d = S_WAIT;
                    cnt_d   = is_long ? P_EXL : P_EX;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_WAIT: begin
                if (last) state_d = S_IDLE;
                else      cnt_d   = cnt_q - 32'd1;
            end
            default: begin
                state_d = S_POWERUP;
                cnt_d   = P_PU;
            end
        endcase
        // E is a flop driven by the next state, so it is high exactly in PULSE.
        e_d = (state_d == S_PULSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_POWERUP;
            cnt_q   <= P_PU;
            rs_q    <= 1'b0;
            rw_q    <= 1'b0;
            data_q  <= '0;
            oe_q    <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            rw_q    <= rw_d;
            data_q  <= data_d;
            oe_q    <= oe_d;
            e_q     <= e_d;
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = ~cmd_ready;
    assign lcd_rs      = rs_q;
    assign lcd_rw      = rw_q;
    assign lcd_e       = e_q;
    assign lcd_data    = data_q;
    assign lcd_data_oe = oe_q;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Directed bench for lcd_bus_driver with short timing parameters.
module tb_lcd_bus_driver;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic [9:0] cmd_data;
    logic       cmd_ready;
    logic       busy;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;
    logic       lcd_data_oe;

    int tests_run;
    int tests_failed;

    lcd_bus_driver #(
        .T_POWERUP  (10),
        .T_SETUP    (2),
        .T_EPW      (4),
        .T_HOLD     (2),
        .T_EXEC     (8),
        .T_EXEC_LONG(20)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .cmd_ready  (cmd_ready),
        .busy       (busy),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_e      (lcd_e),
        .lcd_data   (lcd_data),
        .lcd_data_oe(lcd_data_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_e",     {31'd0, lcd_e},       32'd0);
        check("rst_rs",    {31'd0, lcd_rs},      32'd0);
        check("rst_rw",    {31'd0, lcd_rw},      32'd0);
        check("rst_data",  {24'd0, lcd_data},    32'd0);
        check("rst_oe",    {31'd0, lcd_data_oe}, 32'd0);
        check("rst_ready", {31'd0, cmd_ready},   32'd0);
        check("rst_busy",  {31'd0, busy},        32'd1);
    endtask

    // Called at a negedge; releases reset and times the power-up wait.
    task automatic release_and_time();
        int k;
        int e_hi;
        k = 0;
        e_hi = 0;
        rst_n = 1'b1;
        while (1) begin
            if (cmd_ready === 1'b1 || k >= 100) break;
            @(posedge clk);
            k++;
            @(negedge clk);
            if (lcd_e !== 1'b0) e_hi++;
        end
        check("pu_latency", k, 32'd10);
        check("pu_e_low", e_hi, 32'd0);
    endtask

    // Called at a negedge with cmd_ready high; offers d, then times the
    // transaction and checks pin stability until ready returns.
    task automatic xact(input logic [9:0] d, input int exp_lat, input bit keep);
        int k;
        int e_first;
        int e_cnt;
        int bad;
        check("ready_pre", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_data  = d;
        @(posedge clk);
        @(negedge clk);
        if (!keep) cmd_valid = 1'b0;
        cmd_data = ~d;
        check("ready_post_acc", {31'd0, cmd_ready}, 32'd0);
        check("busy_post_acc",  {31'd0, busy},      32'd1);
        k = 0;
        e_first = -1;
        e_cnt = 0;
        bad = 0;
        while (1) begin
            if (lcd_rs !== d[9] || lcd_rw !== d[8] || lcd_data !== d[7:0] ||
                lcd_data_oe !== ~d[8]) bad++;
            if (lcd_e === 1'b1) begin
                if (e_first < 0) e_first = k;
                e_cnt++;
            end
            if (cmd_ready === 1'b1 || k >= 200) break;
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        check("pins_stable", bad,     32'd0);
        check("e_start",     e_first, 32'd2);
        check("e_width",     e_cnt,   32'd4);
        check("latency",     k,       exp_lat);
        check("idle_e_low",  {31'd0, lcd_e}, 32'd0);
        check("idle_busy",   {31'd0, busy},  32'd0);
    endtask

    initial begin
        int w;
        tests_run    = 0;
        tests_failed = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs();
        release_and_time();

        xact(10'h030, 16, 1'b0);
        xact(10'h001, 28, 1'b0);
        xact(10'h200, 16, 1'b0);
        xact(10'h002, 28, 1'b0);
        xact(10'h004, 16, 1'b0);
        xact(10'h101, 16, 1'b0);
        xact(10'h1FF, 16, 1'b0);
        // Back-to-back: valid never drops, second accepted in first IDLE cycle.
        xact(10'h030, 16, 1'b1);
        xact(10'h20C, 16, 1'b0);

        // Reset during PULSE must drop E without waiting for a clock edge.
        cmd_valid = 1'b1;
        cmd_data  = 10'h2A5;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        w = 0;
        while (lcd_e !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("mid_e_seen", {31'd0, lcd_e}, 32'd1);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs();
        @(negedge clk);
        release_and_time();
        xact(10'h003, 28, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
